// File: rtl/core_pkg.sv
// Shared types and default widths for the store write buffer.
package core_pkg;

    localparam int unsigned WBUF_ADDR_W = 32;
    localparam int unsigned WBUF_DATA_W = 32;
    localparam int unsigned WBUF_STRB_W = WBUF_DATA_W / 8;

    // One buffered store at the default widths.
    typedef struct packed {
        logic [WBUF_ADDR_W-1:0] addr;
        logic [WBUF_DATA_W-1:0] data;
        logic [WBUF_STRB_W-1:0] strb;
    } wbuf_entry_t;

endpackage

// File: rtl/wbuf_fwd_match.sv
// Store-to-load match: parallel word-address compare over all valid entries,
// picking the youngest match (the entry just behind the write pointer wins).
module wbuf_fwd_match #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned STRB_W = 4
) (
    input  logic [DEPTH-1:0][ADDR_W-1:0] entry_addr,
    input  logic [DEPTH-1:0][STRB_W-1:0] entry_strb,
    input  logic [DEPTH-1:0]             entry_valid,
    input  logic [$clog2(DEPTH)-1:0]     wr_ptr,
    input  logic [ADDR_W-1:0]            rd_addr,
    output logic                         hit,
    output logic [$clog2(DEPTH)-1:0]     hit_idx,
    output logic                         partial
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0] match;
    logic [PTR_W-1:0] idx;
    logic             unused_lo;

    // Word-granular address compare against every valid entry.
    always_comb begin
        match = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            match[i] = entry_valid[i] &&
                       (entry_addr[i][ADDR_W-1:2] == rd_addr[ADDR_W-1:2]);
        end
    end

    // Walk from oldest slot (wr_ptr) to youngest (wr_ptr-1); the last match seen wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        partial = 1'b0;
        idx     = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = wr_ptr + PTR_W'(k);
            if (match[idx]) begin
                hit     = 1'b1;
                hit_idx = idx;
                partial = (entry_strb[idx] != '1);
            end
        end
    end

    // Byte-offset bits take no part in the word compare.
    always_comb begin
        unused_lo = ^rd_addr[1:0];
        for (int unsigned i = 0; i < DEPTH; i++) begin
            unused_lo = unused_lo ^ (^entry_addr[i][1:0]);
        end
    end

endmodule

// File: rtl/mem_wr_buf.sv
// Store write buffer between the MEM stage and the data-memory bus.
// In-order circular FIFO with valid/ready drain and store-to-load forwarding.
// Optional feature macro: MEM_WBUF_FWD_EN (full-word data forwarding). When
// undefined, any address match against a pending store raises o_fwdConflict.
module mem_wr_buf
    import core_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = WBUF_ADDR_W,
    parameter int unsigned DATA_W = WBUF_DATA_W
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_wrEn,
    input  logic [ADDR_W-1:0]          i_wrAddr,
    input  logic [DATA_W-1:0]          i_wrData,
    input  logic [DATA_W/8-1:0]        i_wrStrb,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_overflow,
    output logic                       o_busValid,
    output logic [ADDR_W-1:0]          o_busAddr,
    output logic [DATA_W-1:0]          o_busData,
    output logic [DATA_W/8-1:0]        o_busStrb,
    input  logic                       i_busReady,
    input  logic [ADDR_W-1:0]          i_rdAddr,
    output logic                       o_fwdHit,
    output logic [DATA_W-1:0]          o_fwdData,
    output logic                       o_fwdConflict
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned STRB_W = DATA_W / 8;

    logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
    logic [DEPTH-1:0][DATA_W-1:0] data_q;
    logic [DEPTH-1:0][STRB_W-1:0] strb_q;
    logic [DEPTH-1:0]             valid_q;
    logic [PTR_W-1:0]             wr_ptr_q;
    logic [PTR_W-1:0]             rd_ptr_q;
    logic [CNT_W-1:0]             count_q;
    logic                         overflow_q;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             fwd_match;
    logic [PTR_W-1:0] fwd_idx;
    logic             fwd_partial;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = i_wrEn && !full;
    assign pop   = !empty && i_busReady;

    // Entry payload storage; only written on an accepted push.
    always_ff @(posedge i_clk) begin
        if (push) begin
            addr_q[wr_ptr_q] <= i_wrAddr;
            data_q[wr_ptr_q] <= i_wrData;
            strb_q[wr_ptr_q] <= i_wrStrb;
        end
    end

    // Pointers, occupancy, per-slot valid bits and the sticky overflow flag.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (i_wrEn && full) begin
                overflow_q <= 1'b1;
            end
            if (pop) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
            end
            if (push) begin
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Status and bus outputs; head fields read as zero when nothing is pending.
    always_comb begin
        o_full     = full;
        o_empty    = empty;
        o_count    = count_q;
        o_overflow = overflow_q;
        o_busValid = !empty;
        o_busAddr  = empty ? '0 : addr_q[rd_ptr_q];
        o_busData  = empty ? '0 : data_q[rd_ptr_q];
        o_busStrb  = empty ? '0 : strb_q[rd_ptr_q];
    end

    wbuf_fwd_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .STRB_W (STRB_W)
    ) u_fwd_match (
        .entry_addr  (addr_q),
        .entry_strb  (strb_q),
        .entry_valid (valid_q),
        .wr_ptr      (wr_ptr_q),
        .rd_addr     (i_rdAddr),
        .hit         (fwd_match),
        .hit_idx     (fwd_idx),
        .partial     (fwd_partial)
    );

`ifdef MEM_WBUF_FWD_EN
    // Forward only when the youngest matching store covers the whole word.
    always_comb begin
        o_fwdHit      = fwd_match && !fwd_partial;
        o_fwdData     = (fwd_match && !fwd_partial) ? data_q[fwd_idx] : '0;
        o_fwdConflict = fwd_match && fwd_partial;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_idx, fwd_partial};

    // No data path: any overlap with a pending store stalls the load.
    always_comb begin
        o_fwdHit      = 1'b0;
        o_fwdData     = '0;
        o_fwdConflict = fwd_match;
    end
`endif

endmodule

// File: tb/tb_mem_wr_buf.sv
// Self-checking bench for mem_wr_buf: queue-based reference model compared every
// cycle, plus directed checks with hand-computed values.
module tb_mem_wr_buf;
    import core_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        full, empty, ovf, bus_valid, bus_ready;
    logic [2:0]  count;
    logic [31:0] bus_addr, bus_data, rd_addr, fwd_data;
    logic [3:0]  bus_strb;
    logic        fwd_hit, fwd_conf;

    int errors = 0;
    int checks = 0;

    wbuf_entry_t mq[$];
    logic        m_ovf = 1'b0;

    mem_wr_buf #(
        .DEPTH  (DEPTH),
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_wrEn        (wr_en),
        .i_wrAddr      (wr_addr),
        .i_wrData      (wr_data),
        .i_wrStrb      (wr_strb),
        .o_full        (full),
        .o_empty       (empty),
        .o_count       (count),
        .o_overflow    (ovf),
        .o_busValid    (bus_valid),
        .o_busAddr     (bus_addr),
        .o_busData     (bus_data),
        .o_busStrb     (bus_strb),
        .i_busReady    (bus_ready),
        .i_rdAddr      (rd_addr),
        .o_fwdHit      (fwd_hit),
        .o_fwdData     (fwd_data),
        .o_fwdConflict (fwd_conf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: in-order queue, pop uses pre-edge occupancy, push rejected when full.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_ovf <= 1'b0;
        end else begin : upd
            automatic int sz = mq.size();
            if (bus_ready && sz != 0) void'(mq.pop_front());
            if (wr_en && sz == DEPTH) m_ovf <= 1'b1;
            else if (wr_en) mq.push_back('{addr: wr_addr, data: wr_data, strb: wr_strb});
        end
    end

    task automatic compare_all();
        logic        e_hit, e_conf;
        logic [31:0] e_data;
        bit          found;
        e_hit = 1'b0; e_conf = 1'b0; e_data = '0; found = 1'b0;
        for (int i = mq.size() - 1; i >= 0 && !found; i--) begin
            if (mq[i].addr[31:2] == rd_addr[31:2]) begin
                found = 1'b1;
`ifdef MEM_WBUF_FWD_EN
                if (mq[i].strb == 4'hF) begin
                    e_hit = 1'b1;
                    e_data = mq[i].data;
                end else begin
                    e_conf = 1'b1;
                end
`else
                e_conf = 1'b1;
`endif
            end
        end
        chk("m_count", count, mq.size());
        chk("m_empty", empty, mq.size() == 0);
        chk("m_full", full, mq.size() == DEPTH);
        chk("m_ovf", ovf, m_ovf);
        chk("m_valid", bus_valid, mq.size() != 0);
        chk("m_addr", bus_addr, mq.size() != 0 ? mq[0].addr : 32'h0);
        chk("m_data", bus_data, mq.size() != 0 ? mq[0].data : 32'h0);
        chk("m_strb", bus_strb, mq.size() != 0 ? mq[0].strb : 4'h0);
        chk("m_fwd_hit", fwd_hit, e_hit);
        chk("m_fwd_data", fwd_data, e_data);
        chk("m_fwd_conf", fwd_conf, e_conf);
    endtask

    always @(negedge clk) compare_all();

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0;
        bus_ready = 1'b0;
    endtask

    task automatic push_in(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_strb = s;
    endtask

    initial begin
        idle();
        wr_addr = '0; wr_data = '0; wr_strb = '0; rd_addr = '0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_valid", bus_valid, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_hit", fwd_hit, 0);
        chk("rst_conf", fwd_conf, 0);
        step(); step();
        rst_n = 1'b1;

        // Single store, held while the bus stalls
        push_in(32'h100, 32'hDEADBEEF, 4'hF); step(); idle();
        chk("t1_valid", bus_valid, 1);
        chk("t1_addr", bus_addr, 32'h100);
        chk("t1_data", bus_data, 32'hDEADBEEF);
        chk("t1_strb", bus_strb, 4'hF);
        chk("t1_count", count, 1);
        repeat (5) begin
            step();
            chk("t1_hold_addr", bus_addr, 32'h100);
            chk("t1_hold_data", bus_data, 32'hDEADBEEF);
            chk("t1_hold_valid", bus_valid, 1);
        end
        bus_ready = 1'b1; step(); idle();
        chk("t1_empty", empty, 1);

        // Fill, overflow, full-with-pop, drain
        for (int i = 0; i < 4; i++) begin
            push_in(32'h400 + 32'(16 * i), 32'hA0000000 + 32'(i), 4'hF); step();
        end
        wr_en = 1'b0;
        chk("t2_full", full, 1);
        chk("t2_count", count, 4);
        push_in(32'hBAD0, 32'hBAD, 4'hF); step(); wr_en = 1'b0;
        chk("t2_ovf", ovf, 1);
        chk("t2_count_ovf", count, 4);
        chk("t2_head", bus_addr, 32'h400);
        push_in(32'hBAD4, 32'hBAD, 4'hF); bus_ready = 1'b1; step(); idle();
        chk("t2_popfull_count", count, 3);
        chk("t2_popfull_head", bus_addr, 32'h410);
        chk("t2_popfull_full", full, 0);
        bus_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            chk("t2_order", bus_addr, 32'h400 + 32'(16 * i));
            chk("t2_order_data", bus_data, 32'hA0000000 + 32'(i));
            step();
        end
        idle();
        chk("t2_empty", empty, 1);
        chk("t2_ovf_sticky", ovf, 1);

        // Streaming push+pop with wrap
        bus_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push_in(32'(4 * i), 32'h1000 + 32'(i), 4'hF); step();
            chk("t3_count", count, 1);
            chk("t3_addr", bus_addr, 32'(4 * i));
        end
        wr_en = 1'b0; step(); idle();
        chk("t3_empty", empty, 1);

        // Forwarding from the youngest of two same-word stores
        push_in(32'h200, 32'h11111111, 4'hF); step();
        push_in(32'h200, 32'h22222222, 4'hF); step(); idle();
        rd_addr = 32'h202; #1;
`ifdef MEM_WBUF_FWD_EN
        chk("t4_hit", fwd_hit, 1);
        chk("t4_data", fwd_data, 32'h22222222);
        chk("t4_conf", fwd_conf, 0);
`else
        chk("t4_hit", fwd_hit, 0);
        chk("t4_data", fwd_data, 0);
        chk("t4_conf", fwd_conf, 1);
`endif
        rd_addr = 32'h204; #1;
        chk("t4_miss_hit", fwd_hit, 0);
        chk("t4_miss_conf", fwd_conf, 0);
        bus_ready = 1'b1; step(); step(); idle();
        rd_addr = 32'h202; #1;
        chk("t4_popped_conf", fwd_conf, 0);
        chk("t4_popped_hit", fwd_hit, 0);

        // Partial strobes block forwarding; a younger full store overrides
        push_in(32'h300, 32'h12345678, 4'b0011); step(); idle();
        rd_addr = 32'h300; #1;
        chk("t5_conf", fwd_conf, 1);
        chk("t5_hit", fwd_hit, 0);
        push_in(32'h300, 32'hCAFEF00D, 4'hF); step(); idle(); #1;
`ifdef MEM_WBUF_FWD_EN
        chk("t5_young_hit", fwd_hit, 1);
        chk("t5_young_data", fwd_data, 32'hCAFEF00D);
`else
        chk("t5_young_conf", fwd_conf, 1);
`endif
        push_in(32'h300, 32'h55, 4'b1000); step(); idle(); #1;
        chk("t5_part_conf", fwd_conf, 1);
        bus_ready = 1'b1; repeat (3) step(); idle();
        chk("t5_empty", empty, 1);

        // Asynchronous reset with entries pending
        for (int i = 0; i < 3; i++) begin
            push_in(32'h500 + 32'(4 * i), 32'h77000000 + 32'(i), 4'hF); step();
        end
        idle();
        chk("t6_count_pre", count, 3);
        @(posedge clk); #3;
        rst_n = 1'b0; #1;
        chk("t6_count", count, 0);
        chk("t6_valid", bus_valid, 0);
        chk("t6_empty", empty, 1);
        chk("t6_addr", bus_addr, 0);
        chk("t6_ovf", ovf, 0);
        chk("t6_conf", fwd_conf, 0);
        bus_ready = 1'b1;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) begin
            step();
            chk("t6_no_bus", bus_valid, 0);
        end
        idle();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
